// File: rtl/fp_pkg.sv
// Shared float-format constants and FSM encoding for the integer/float conversion units.
// The field slices are reusable by the float adder and the other units that decode this format.
package fp_pkg;

  localparam int EXP_BIAS   = 127;
  localparam int FRAC_WIDTH = 23;

  // Exponent of a 32-bit integer whose MSB is bit 31, before normalisation.
  localparam logic [7:0] INT_EXP_TOP = 8'(EXP_BIAS + 31);

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int FRAC_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

endpackage

// File: rtl/int2fp_round.sv
// Round-to-nearest-even of a normalised 32-bit magnitude (bit 31 set) into a 23-bit fraction.
// A fraction carry-out bumps the exponent; the largest input gives 159, so there is no overflow to Inf.
module int2fp_round
  import fp_pkg::*;
(
  input  logic [31:0]           i_mag,
  input  logic [7:0]            i_exp,
  output logic [FRAC_WIDTH-1:0] o_frac,
  output logic [7:0]            o_exp,
  output logic                  o_inexact
);

  logic [FRAC_WIDTH-1:0] w_frac;
  logic                  w_guard;
  logic                  w_sticky;
  logic                  w_round_up;
  logic [FRAC_WIDTH:0]   w_sum;

  // Bit 31 is the hidden one; the next 23 bits are stored, the rest decide rounding.
  assign w_frac     = i_mag[30:8];
  assign w_guard    = i_mag[7];
  assign w_sticky   = |i_mag[6:0];
  assign w_round_up = w_guard & (w_sticky | w_frac[0]);

  assign w_sum     = {1'b0, w_frac} + (FRAC_WIDTH+1)'(w_round_up);
  assign o_frac    = w_sum[FRAC_WIDTH-1:0];
  assign o_exp     = i_exp + 8'(w_sum[FRAC_WIDTH]);
  assign o_inexact = w_guard | w_sticky;

endmodule

// File: rtl/int_to_float.sv
// Iterative 32-bit integer (signed or unsigned) to IEEE-754 single converter.
// Takes the magnitude, normalises one bit per cycle, then rounds to nearest even.
module int_to_float
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        iStart,
  input  logic [31:0] iInt,
  input  logic        iSigned,
  output logic [31:0] oF,
  output logic        oDone,
  output logic        oBusy,
  output logic        oInexact
);

  state_t      r_state;
  logic [31:0] r_int;
  logic        r_signed;
  logic        r_sign;
  logic [31:0] r_mag;
  logic [7:0]  r_exp;

  logic                  w_neg;
  logic [31:0]           w_abs;
  logic [FRAC_WIDTH-1:0] w_frac;
  logic [7:0]            w_exp;
  logic                  w_inexact;
  logic [31:0]           w_packed;

  // Negating 0x80000000 yields 0x80000000, which is the right unsigned magnitude.
  assign w_neg = r_signed & r_int[31];
  assign w_abs = w_neg ? (~r_int + 32'd1) : r_int;

  assign oBusy = (r_state != S_IDLE);

  int2fp_round u_round (
    .i_mag     (r_mag),
    .i_exp     (r_exp),
    .o_frac    (w_frac),
    .o_exp     (w_exp),
    .o_inexact (w_inexact)
  );

  always_comb begin
    w_packed                     = '0;
    w_packed[SIGN_BIT]           = r_sign;
    w_packed[EXP_MSB:EXP_LSB]    = w_exp;
    w_packed[FRAC_MSB:FRAC_LSB]  = w_frac;
  end

  // NOTE: async active-low reset clears every register, so an abort mid-conversion leaves no stale result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_int    <= '0;
      r_signed <= 1'b0;
      r_sign   <= 1'b0;
      r_mag    <= '0;
      r_exp    <= '0;
      oF       <= '0;
      oDone    <= 1'b0;
      oInexact <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_int    <= iInt;
            r_signed <= iSigned;
            r_state  <= S_ABS;
          end
        end
        S_ABS: begin
          r_sign <= w_neg;
          r_mag  <= w_abs;
          r_exp  <= INT_EXP_TOP;
          if (w_abs == '0) begin
            oF       <= '0;
            oInexact <= 1'b0;
            oDone    <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (!r_mag[31]) begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - 8'd1;
          end else begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          oF       <= w_packed;
          oInexact <= w_inexact;
          oDone    <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          oDone   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Self-checking bench for int_to_float: directed corner cases, handshake and reset abort,
// then a randomised sweep against an arithmetic reference model.
module tb_int_to_float;

  logic        clk;
  logic        resetn;
  logic        iStart;
  logic [31:0] iInt;
  logic        iSigned;
  logic [31:0] oF;
  logic        oDone;
  logic        oBusy;
  logic        oInexact;

  int n_tests  = 0;
  int n_failed = 0;

  int_to_float dut (
    .clk      (clk),
    .resetn   (resetn),
    .iStart   (iStart),
    .iInt     (iInt),
    .iSigned  (iSigned),
    .oF       (oF),
    .oDone    (oDone),
    .oBusy    (oBusy),
    .oInexact (oInexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: value / 2^msb rounded to 24 significant bits, nearest-even, by integer arithmetic.
  function automatic void ref_conv(input logic [31:0] v, input logic s,
                                   output logic [31:0] f, output logic inex, output int lat);
    longint unsigned m, q, rem, half;
    int   msb, e, shift;
    logic neg;
    neg = s && v[31];
    m   = {32'd0, v};
    if (neg) m = 64'h1_0000_0000 - m;
    if (m == 0) begin
      f = '0; inex = 1'b0; lat = 1;
      return;
    end
    msb = 0;
    for (int i = 0; i < 32; i++) if (m[i]) msb = i;
    e   = 127 + msb;
    lat = 3 + (31 - msb);
    if (msb <= 23) begin
      q    = m << (23 - msb);
      inex = 1'b0;
    end else begin
      shift = msb - 23;
      q     = m >> shift;
      rem   = m & ((64'd1 << shift) - 1);
      half  = 64'd1 << (shift - 1);
      inex  = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    f = {neg, 8'(e), q[22:0]};
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns #1 after the edge that leaves S_DONE.
  task automatic run_conv(input logic [31:0] v, input logic s,
                          output logic [31:0] f, output logic inex, output int lat);
    iInt    = v;
    iSigned = s;
    iStart  = 1'b1;
    @(posedge clk); #1;
    iStart  = 1'b0;
    iInt    = $urandom;
    iSigned = 1'($urandom_range(0, 1));
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!oDone && lat < 100);
    f    = oF;
    inex = oInexact;
    check("done_seen", {31'd0, oDone}, 32'd1);
    @(posedge clk); #1;
    check("done_pulse", {31'd0, oDone}, 32'd0);
    check("idle_after", {31'd0, oBusy}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] v;
    logic        s;
    logic [31:0] f;
    logic        inex;
    int          lat;
  } vec_t;

  vec_t dir_vecs[$];

  initial begin
    logic [31:0] f, ef, v;
    logic        inex, einex, s;
    int          lat, elat, dones;

    resetn = 1'b0; iStart = 1'b0; iInt = '0; iSigned = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_oF",      oF,                  32'd0);
    check("rst_oDone",   {31'd0, oDone},      32'd0);
    check("rst_oBusy",   {31'd0, oBusy},      32'd0);
    check("rst_inexact", {31'd0, oInexact},   32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    dir_vecs = '{
      '{32'h0000_0001, 1'b1, 32'h3F80_0000, 1'b0, 34},
      '{32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 34},
      '{32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1},
      '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1},
      '{32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 3},
      '{32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0, 3},
      '{32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 10},
      '{32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1, 10},
      '{32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1, 3}
    };
    foreach (dir_vecs[i]) begin
      run_conv(dir_vecs[i].v, dir_vecs[i].s, f, inex, lat);
      check("dir_oF",      f,                 dir_vecs[i].f);
      check("dir_inexact", {31'd0, inex},     {31'd0, dir_vecs[i].inex});
      check("dir_latency", 32'(lat),          32'(dir_vecs[i].lat));
    end

    // A second iStart while busy must be dropped.
    iInt = 32'h0000_0100; iSigned = 1'b0; iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_during", {31'd0, oBusy}, 32'd1);
    iInt = 32'h0000_0007; iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    dones = 0; f = '0;
    repeat (60) begin
      @(posedge clk); #1;
      if (oDone) begin
        dones++;
        f = oF;
      end
    end
    check("ignore_dones", 32'(dones), 32'd1);
    check("ignore_oF",    f,          32'h4380_0000);

    // Reset in the middle of normalisation aborts at once.
    iInt = 32'h0000_0100; iSigned = 1'b0; iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("abort_oF",    oF,             32'd0);
    check("abort_oDone", {31'd0, oDone}, 32'd0);
    check("abort_oBusy", {31'd0, oBusy}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (oDone) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_idle",    {31'd0, oBusy}, 32'd0);

    // Random sweep; half the values are shifted down to spread the leading-zero count.
    for (int n = 0; n < 2500; n++) begin
      v = $urandom;
      if ($urandom_range(0, 1) == 1) v = v >> $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      ref_conv(v, s, ef, einex, elat);
      run_conv(v, s, f, inex, lat);
      check("rnd_oF",      f,             ef);
      check("rnd_inexact", {31'd0, inex}, {31'd0, einex});
      check("rnd_latency", 32'(lat),      32'(elat));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
